// File: rtl/booth_r4_seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// booth_mul_pkg
// Shared types and helpers for the radix-4 Booth multiplier family.
//   state_e        : sequencer states (IDLE / CALC / DONE)
//   booth_digit_t  : recoded digit {neg, one, two}; the selected value is
//                    zero, +/-1 or +/-2 times the multiplicand
//   ext_width()    : width of the extended operands (N+2)
//   iter_count()   : number of Booth digits retired for an N-bit operand
//   decode_triplet : {b[2i+1], b[2i], b[2i-1]} -> booth_digit_t
// ---------------------------------------------------------------------------
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Two guard bits are needed so that an unsigned N-bit operand still
    // reads as a non-negative two's-complement value with an even width.
    function automatic int ext_width(input int n);
        return n + 2;
    endfunction

    function automatic int iter_count(input int n);
        return (n + 2) / 2;
    endfunction

    // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
    // 111 is encoded with neg = 0 so a zero digit never produces -0.
    function automatic booth_digit_t decode_triplet(input logic [2:0] t);
        booth_digit_t d;
        d.neg = t[2] & ~(t[1] & t[0]);
        d.one = t[1] ^ t[0];
        d.two = (t == 3'b011) || (t == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_mul_if
// Operand/result handshake bundle for booth_r4_seq_mul.
//   in_valid / in_ready   : operand request / block can accept
//   a, b (N bits), mode   : multiplicand, multiplier, 0=unsigned 1=signed
//   out_valid / out_ready : product available / consumer accepts
//   p (2N bits)           : full product
// Modports: master = operand issuer and result consumer; slave = multiplier.
// ---------------------------------------------------------------------------
interface booth_r4_seq_mul_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/booth_r4_digit_enc.sv
// ---------------------------------------------------------------------------
// booth_r4_digit_enc
// Combinational radix-4 Booth recoder.
//   triplet (3 bits) : {b[2i+1], b[2i], b[2i-1]}
//   digit            : {neg, one, two} selecting 0, +/-a or +/-2a
// Kept as its own module so parallel multiplier variants can replicate it.
// ---------------------------------------------------------------------------
module booth_r4_digit_enc
    import booth_mul_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);
    assign digit = decode_triplet(triplet);
endmodule

// File: rtl/booth_r4_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_mul
// Sequential radix-4 Booth multiplier returning the full 2N-bit product,
// one Booth digit per clock, valid/ready on both sides.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : booth_r4_seq_mul_if.slave (in_valid/in_ready, a, b, mode,
//          out_valid/out_ready, p)
// Parameter N: operand width, even and >= 4.
// Optional build macro BOOTH_R4_SEQ_MUL_EARLY_EXIT_EN: leave CALC as soon as
// every remaining digit is known to be zero (variable latency, identical
// results). Undefined: fixed N/2+1 CALC cycles.
// ---------------------------------------------------------------------------
module booth_r4_seq_mul
    import booth_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_r4_seq_mul_if.slave    bus
);
    localparam int W     = ext_width(N);
    localparam int ITERS = iter_count(N);
    localparam int ACC_W = 2 * N + 2;
    localparam int SH_W  = W + 1;            // extended multiplier + lookback
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    if (((N % 2) != 0) || (N < 4)) begin : g_bad_n
        $error("booth_r4_seq_mul: N must be even and >= 4");
    end

    state_e                   state_q, state_d;
    logic signed [W-1:0]      mcand_q, mcand_d;
    logic [SH_W-1:0]          mplr_q,  mplr_d;
    logic signed [ACC_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic [2*N-1:0]           p_q,     p_d;

    booth_digit_t             digit;
    logic signed [W:0]        pp_mag;
    logic signed [W:0]        pp;
    logic signed [ACC_W-1:0]  pp_sh;
    logic [SH_W-1:0]          mplr_next;
    logic                     last_iter;

    // Low three bits of the shifting multiplier are always the current
    // triplet; bit 0 starts as the zero lookback bit.
    booth_r4_digit_enc u_enc (
        .triplet (mplr_q[2:0]),
        .digit   (digit)
    );

    always_comb begin
        pp_mag = '0;
        if (digit.two) begin
            pp_mag = {mcand_q, 1'b0};
        end else if (digit.one) begin
            pp_mag = {mcand_q[W-1], mcand_q};
        end
    end

    assign pp    = digit.neg ? -pp_mag : pp_mag;
    assign pp_sh = $signed({{(N-1){pp[W]}}, pp}) <<< {cnt_q, 1'b0};

    // Arithmetic shift keeps the sign/zero extension of the multiplier
    // replicated above the unprocessed bits, so the register stays a faithful
    // image of "remaining bits + lookback".
    assign mplr_next = {{2{mplr_q[SH_W-1]}}, mplr_q[SH_W-1:2]};

`ifdef BOOTH_R4_SEQ_MUL_EARLY_EXIT_EN
    // Uniform remaining bits recode to all-zero digits.
    logic rest_uniform;
    assign rest_uniform = (mplr_next == '0) || (mplr_next == '1);
    assign last_iter    = (cnt_q == LAST_CNT) || rest_uniform;
`else
    assign last_iter    = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = {{2{bus.mode & bus.a[N-1]}}, bus.a};
                    mplr_d  = {{2{bus.mode & bus.b[N-1]}}, bus.b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + pp_sh;
                mplr_d = mplr_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    // Product is exact modulo 2^(2N+2); low 2N bits are the result.
                    p_d     = acc_d[2*N-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.p         = p_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_seq_mul
// Directed bench for booth_r4_seq_mul (N = 8) with a behavioural product model
// for the continuous-issue sweep. Honours BOOTH_R4_SEQ_MUL_EARLY_EXIT_EN for
// latency expectations.
// ---------------------------------------------------------------------------
module tb_booth_r4_seq_mul;
    localparam int N = 8;
`ifdef BOOTH_R4_SEQ_MUL_EARLY_EXIT_EN
    localparam int LAT_B01 = 1;
`else
    localparam int LAT_B01 = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    booth_r4_seq_mul_if #(.N(N)) bus ();

    booth_r4_seq_mul #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic m);
        longint xv, yv, pr;
        xv = m ? longint'($signed(x)) : longint'(x);
        yv = m ? longint'($signed(y)) : longint'(y);
        pr = xv * yv;
        return pr[15:0];
    endfunction

    // Issue one operation from IDLE and wait (bounded) for out_valid.
    // lat = edges after the accepting edge, -1 on timeout.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xm,
                          output logic [15:0] rp, output int lat);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = xa;
        bus.b         = xb;
        bus.mode      = xm;
        tick();
        bus.in_valid  = 1'b0;
        bus.a         = 'x;
        bus.b         = 'x;
        bus.mode      = 1'bx;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        rp = bus.p;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.p !== 16'h0000) begin errors++; $display("FAIL reset_p got=%h want=0000", bus.p); end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_max();
        logic [15:0] rp;
        int lat;
        run_op(8'hFF, 8'hFF, 1'b0, rp, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL umax_latency got=%0d want=5", lat); end
        checks++; if (rp !== 16'hFE01) begin errors++; $display("FAIL umax_p got=%h want=fe01", rp); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got=%b want=0", bus.in_ready); end
        retire();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL retire_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL retire_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.p !== 16'hFE01) begin errors++; $display("FAIL p_retained got=%h want=fe01", bus.p); end
    endtask

    task automatic test_signed();
        logic [15:0] rp;
        int lat;
        run_op(8'h80, 8'h80, 1'b1, rp, lat);
        checks++; if (rp !== 16'h4000) begin errors++; $display("FAIL s_min_sq got=%h want=4000", rp); end
        retire();
        run_op(8'h05, 8'hFD, 1'b1, rp, lat);
        checks++; if (rp !== 16'hFFF1) begin errors++; $display("FAIL s_5_m3 got=%h want=fff1", rp); end
        retire();
        run_op(8'h05, 8'hFD, 1'b0, rp, lat);
        checks++; if (rp !== 16'h04F1) begin errors++; $display("FAIL u_5_253 got=%h want=04f1", rp); end
        retire();
        run_op(8'h7F, 8'h80, 1'b1, rp, lat);
        checks++; if (rp !== 16'hC080) begin errors++; $display("FAIL s_127_m128 got=%h want=c080", rp); end
        retire();
    endtask

    task automatic test_zero();
        logic [15:0] rp;
        int lat;
        run_op(8'h00, 8'hAB, 1'b1, rp, lat);
        checks++; if (rp !== 16'h0000) begin errors++; $display("FAIL zero_a got=%h want=0000", rp); end
        retire();
        run_op(8'h9C, 8'h00, 1'b0, rp, lat);
        checks++; if (rp !== 16'h0000) begin errors++; $display("FAIL zero_b got=%h want=0000", rp); end
        retire();
    endtask

    task automatic test_latency();
        logic [15:0] rp;
        int lat;
        run_op(8'h7F, 8'h01, 1'b0, rp, lat);
        checks++; if (lat !== LAT_B01) begin errors++; $display("FAIL lat_b01 got=%0d want=%0d", lat, LAT_B01); end
        checks++; if (rp !== 16'h007F) begin errors++; $display("FAIL p_b01 got=%h want=007f", rp); end
        retire();
        run_op(8'h7F, 8'hFF, 1'b0, rp, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL lat_bff got=%0d want=5", lat); end
        checks++; if (rp !== 16'h7E81) begin errors++; $display("FAIL p_bff got=%h want=7e81", rp); end
        retire();
    endtask

    task automatic test_backpressure();
        logic [15:0] rp;
        int lat;
        run_op(8'h12, 8'h34, 1'b0, rp, lat);
        checks++; if (rp !== 16'h03A8) begin errors++; $display("FAIL bp_first got=%h want=03a8", rp); end
        bus.in_valid = 1'b1;
        bus.mode     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.a = 8'h20 + 8'(k);
            bus.b = 8'h31 + 8'(k);
            tick();
            checks++; if (bus.p !== 16'h03A8) begin errors++; $display("FAIL bp_p_stable got=%h want=03a8", bus.p); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        end
        bus.a = 8'h0F;
        bus.b = 8'h0F;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        bus.a = 'x;
        bus.b = 'x;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b want=0", bus.in_ready); end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat < 0) begin errors++; $display("FAIL bp_timeout got=%0d want=done", lat); end
        checks++; if (bus.p !== 16'h00E1) begin errors++; $display("FAIL bp_second got=%h want=00e1", bus.p); end
        retire();
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] rp;
        int lat;
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h66;
        bus.mode     = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.p !== 16'h0000) begin errors++; $display("FAIL rmid_p got=%h want=0000", bus.p); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", bus.in_ready); end
        #1 rst = 1'b0;
        tick();
        repeat (6) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_discard got=%b want=0", bus.out_valid); end
        run_op(8'h03, 8'h07, 1'b0, rp, lat);
        checks++; if (rp !== 16'h0015) begin errors++; $display("FAIL rmid_after got=%h want=0015", rp); end
        retire();
    endtask

    task automatic test_back_to_back();
        localparam int NS = 1000;
        logic [15:0] exp_q[$];
        logic [15:0] e;
        logic [7:0]  na, nb;
        logic        will, need;
        int          got, acc, cyc, last;
        got = 0; acc = 0; cyc = 0; last = -1;
        need = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        while ((got < NS) && (cyc < NS * 8 + 100)) begin
            if (need) begin
                na = 8'($urandom);
                nb = 8'($urandom);
                if (acc % 16 == 3)  na = 8'h00;
                if (acc % 16 == 11) nb = 8'h00;
                if (acc % 16 == 7)  begin na = 8'h80; nb = 8'h80; end
                if (acc % 16 == 13) begin na = 8'hFF; nb = 8'hFF; end
                bus.a    = na;
                bus.b    = nb;
                bus.mode = acc[0];
                need = 1'b0;
            end
            will = bus.in_ready;
            tick();
            cyc++;
            if (will) begin
                exp_q.push_back(ref_mul(bus.a, bus.b, bus.mode));
                acc++;
                need = 1'b1;
            end
            checks++;
            if (bus.in_ready && bus.out_valid) begin
                errors++; $display("FAIL b2b_overlap in_ready=%b out_valid=%b want not both", bus.in_ready, bus.out_valid);
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious got=%h want=no result", bus.p);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.p !== e) begin errors++; $display("FAIL b2b_product idx=%0d got=%h want=%h", got, bus.p, e); end
                end
`ifndef BOOTH_R4_SEQ_MUL_EARLY_EXIT_EN
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 7) begin errors++; $display("FAIL b2b_period got=%0d want=7", cyc - last); end
                end
`endif
                last = cyc;
                got++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (got != NS) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", got, NS); end
        tick();
        bus.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_zero();
        test_latency();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
